// File: rtl/pattern_sched_pkg.sv
// Shared types and constants for the burst scheduler that fronts one
// pattern generator.
package pattern_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam logic MODE_ODD  = 1'b0;
  localparam logic MODE_EVEN = 1'b1;

endpackage

// File: rtl/pattern_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and returns
// the first requester found as a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_gnt;

  // Rotate so the pointer lands on bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    rot     = N'({req, req} >> ptr);
    rot_gnt = rot & (~rot + N'(1));
    gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
  end

endmodule

// File: rtl/pattern_sched.sv
// Round-robin burst scheduler sharing one pattern generator; a PRIME cycle
// toggles the generator input so every granted burst restarts from Y = 0.
module pattern_sched
  import pattern_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       mode,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  gen_en,
  output logic                  gen_in
);

  localparam int PTR_W = $clog2(NREQ);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [LEN_W-1:0]   cur_len_reg, cur_len_next;
  logic               cur_mode_reg, cur_mode_next;
  logic [NREQ-1:0]    grant_reg, grant_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;
  logic               gen_en_reg, gen_en_next;
  logic               gen_in_reg, gen_in_next;

  logic [NREQ-1:0]    arb_gnt;
  logic [LEN_W-1:0]   len_masked [NREQ];
  logic [LEN_W-1:0]   sel_len;
  logic               sel_mode;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_adv;
  logic               launch;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_masked[gi] = arb_gnt[gi] ? len[gi*LEN_W +: LEN_W] : '0;
  end

  always_comb begin
    sel_len = '0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_len = sel_len | len_masked[k];
      if (arb_gnt[k]) win_idx = PTR_W'(k);
    end
    sel_mode = |(mode & arb_gnt);
    ptr_adv  = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    cur_len_next  = cur_len_reg;
    cur_mode_next = cur_mode_reg;
    grant_next    = grant_reg;
    done_next     = 1'b0;
    aborted_next  = 1'b0;
    launch        = 1'b0;

    case (state_reg)
      IDLE: launch = |req;
      PRIME: begin
        if (abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (cnt_reg == cur_len_reg) begin
          // Arbitrate on the last beat so the next burst follows with no gap.
          state_next = IDLE;
          done_next  = 1'b1;
          launch     = |req;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (launch) begin
      state_next    = PRIME;
      grant_next    = arb_gnt;
      cur_mode_next = sel_mode;
      cur_len_next  = sel_len;
      ptr_next      = ptr_adv;
    end else if (state_next == IDLE) begin
      grant_next = '0;
    end

    busy_next   = (state_next != IDLE);
    gen_en_next = busy_next;
    case (state_next)
      PRIME:   gen_in_next = ~cur_mode_next;
      RUN:     gen_in_next = cur_mode_next;
      default: gen_in_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      cur_len_reg  <= '0;
      cur_mode_reg <= MODE_ODD;
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      gen_en_reg   <= 1'b0;
      gen_in_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      cur_len_reg  <= cur_len_next;
      cur_mode_reg <= cur_mode_next;
      grant_reg    <= grant_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      aborted_reg  <= aborted_next;
      gen_en_reg   <= gen_en_next;
      gen_in_reg   <= gen_in_next;
    end
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign aborted = aborted_reg;
  assign gen_en  = gen_en_reg;
  assign gen_in  = gen_in_reg;

endmodule

// File: doc/pattern_sched.md
# pattern_sched

Burst scheduler that shares one pattern-generator instance among `NREQ` requesters. Each requester asks for a burst of a given mode (odd or even ramp) and length. The block arbitrates round-robin and drives the generator's `en`/`in` inputs so that every granted burst starts from `Y = 0`. It sits directly in front of the pattern generator; the generator's `Y` is consumed by the granted requester while its `grant` bit is high.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `LEN_W`, 4: burst-length field width; burst run length = `len + 1` cycles.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `NREQ`  per-requester burst request; level, held until granted.
- `mode`  in  `NREQ`  per-requester mode; 0 = odd ramp, 1 = even ramp; sampled at grant.
- `len`  in  `NREQ*LEN_W`  per-requester length, slice i = `len[i*LEN_W +: LEN_W]`; sampled at grant.
- `abort`  in  1  terminates the active burst.
- `grant`  out  `NREQ`  one-hot owner of the generator; all-zero when idle.
- `busy`  out  1  high in PRIME or RUN.
- `done`  out  1  one-cycle pulse after a burst completes normally.
- `aborted`  out  1  one-cycle pulse after a burst is aborted.
- `gen_en`  out  1  drives the generator `en`.
- `gen_in`  out  1  drives the generator `in`.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - `gen_en = 0`; generator output is don't-care.
  - If any `req` is high, the arbiter picks the winner. Go to PRIME.
  - Latch the winner's `mode` into `cur_mode` and its `len` into `cur_len`.
  - Set `grant` one-hot to the winner.
  - Move the round-robin pointer to winner+1 (mod `NREQ`).
- PRIME (1 cycle):
  - `gen_en = 1`, `gen_in = ~cur_mode`.
  - Purpose: the following RUN cycle presents a change on `in`, forcing the generator to `Y = 0`.
- RUN:
  - `gen_en = 1`, `gen_in = cur_mode`.
  - Beat counter runs 0..`cur_len`.
  - At `cur_len`, go to IDLE and pulse `done` for the next cycle.
- Arbitration is round-robin, starting the search at the pointer. Pointer reset value is 0, so requester 0 has priority first.
- Request changes while busy:
  - `req`, `mode` and `len` changes during PRIME/RUN are ignored.
  - A requester dropping `req` while busy does not cancel its burst.
- `abort`:
  - Effective in PRIME or RUN. Next cycle: IDLE, `grant = 0`, `gen_en = 0`, `aborted` pulses, `done` stays low.
  - Ignored in IDLE.
- `abort` coinciding with the final RUN beat: abort wins; `aborted` pulses, `done` does not.
- Back-to-back bursts: `done` and a new grant may occur in the same cycle. The PRIME cycle guarantees the restart even when the new mode equals the previous one.
- Width rules:
  - Beat counter is `LEN_W` bits and never wraps; the compare is against `cur_len`.
  - `len = 2^LEN_W - 1` gives `2^LEN_W` RUN cycles.

## Timing
- All outputs are registered. Reset values: `grant = 0`, `busy = 0`, `done = 0`, `aborted = 0`, `gen_en = 0`, `gen_in = 0`; state IDLE; pointer 0.
- `rst` asserted mid-burst forces the reset values immediately (asynchronously). No `done` or `aborted` pulse is produced.
- Request latency:
  - Edge 0: `req` sampled.
  - After edge 1: `grant`/`busy` high, PRIME.
  - After edge 2: RUN starts.
  - The generator shows `Y = 0` after edge 3.
- Burst occupancy: 1 PRIME + (`len`+1) RUN cycles.
- `done` is high for exactly the cycle after the last RUN cycle. `grant` is already low in that cycle, or already switched to the next winner.

## Structure
- `pattern_sched_pkg` holds:
  - state enum (IDLE, PRIME, RUN);
  - `MODE_ODD = 1'b0`, `MODE_EVEN = 1'b1`.
- Sub-module `rr_arbiter`:
  - parameter `N`; inputs `req[N]`, `ptr`; output `gnt` one-hot;
  - combinational, pointer register kept in `pattern_sched`.
- Generator instance stays outside; the bench instantiates it with `pattern_sched`.

## Test plan
- Single burst: `req[2] = 1`, `mode[2] = 0`, `len = 3` -> `grant = 4'b0100` for 5 cycles. Generator `Y` = 0, 1, 3, 5; `done` pulses once.
- Round-robin: `req = 4'b1011` held continuously -> grants in order 0, 1, 3, 0. No gap cycle between `done` and the next grant.
- Same-mode back-to-back: two even bursts (`len = 2`) from requesters 0 and 1 -> the second burst's `Y` restarts 0, 2, 4, not continuing from 4.
- Abort: abort asserted on RUN beat 1 of a `len = 5` burst -> next cycle `grant = 0`, `gen_en = 0`, `aborted = 1`, `done` never pulses. A pending request is granted after that.
- Abort on last beat: `len = 0`, abort in the single RUN cycle -> `aborted = 1`, `done = 0`.
- Reset mid-RUN: `rst` pulsed asynchronously between edges -> all outputs 0 immediately, pointer 0. The next `req = 4'b1111` grants requester 0.
